// File: rtl/seq_prio_encoder.sv
// Sequential multi-hot to binary encoder: emits one index beat per set bit of a loaded vector.
// Define SEQ_PRIO_ENCODER_LSB_FIRST_EN to emit ascending indices instead of MSB-first.
module seq_prio_encoder #(
  parameter int unsigned W  = 8,
  parameter int unsigned IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  req,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [IW-1:0] idx,
  output logic          none,
  output logic          last,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   pending_q, pending_d;
  logic           zero_q, zero_d;
  logic [IW-1:0]  hit_idx;
  logic           single;
  logic           busy;

  // Priority pick: the last match in the scan order wins.
  always_comb begin
    hit_idx = '0;
`ifdef SEQ_PRIO_ENCODER_LSB_FIRST_EN
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (pending_q[i]) hit_idx = IW'(i);
    end
`else
    for (int i = 0; i < int'(W); i++) begin
      if (pending_q[i]) hit_idx = IW'(i);
    end
`endif
  end

  assign single = (pending_q != '0) && ((pending_q & (pending_q - W'(1))) == '0);
  assign busy   = (state_q == StBusy);

  always_comb begin
    in_ready  = ~busy;
    out_valid = busy;
    idx       = busy ? hit_idx : '0;
    none      = busy & zero_q;
    last      = busy & (zero_q | single);
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          pending_d = req;
          zero_d    = (req == '0);
          state_d   = StBusy;
        end
      end
      StBusy: begin
        if (out_ready) begin
          pending_d = pending_q & ~(W'(1) << hit_idx);
          if (last) begin
            state_d = StIdle;
            zero_d  = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

endmodule
